// File: rtl/banda_pkg.sv
// banda_pkg: shared constants and types for the Banda output collector.
//   WORD_W      - collected word width (f bits packed LSB-first)
//   LATENCY_DEF - default load-to-result latency of the assembly line
//   DEPTH_DEF   - default output FIFO depth in words
//   pack_state_e - packer FSM states
package banda_pkg;

   localparam int unsigned WORD_W      = 8;
   localparam int unsigned LATENCY_DEF = 3;
   localparam int unsigned DEPTH_DEF   = 4;

   typedef enum logic [0:0] {
      EMPTY,
      FILLING
   } pack_state_e;

endpackage

// File: rtl/banda_sync_fifo.sv
// banda_sync_fifo: first-word fall-through synchronous FIFO with sticky overflow.
//   clk_i, rst_ni         - clock, asynchronous active-low reset
//   wr_en_i, wr_data_i    - push request and word
//   rd_en_i               - consumer ready; pops when a word is available
//   rd_data_o, valid_o    - oldest word (zero when empty) and non-empty flag
//   count_o               - words held, 0..Depth
//   overflow_o            - set when a push is dropped because the FIFO is full
module banda_sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic [Width-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [Width-1:0]         rd_data_o,
   output logic                     valid_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     overflow_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             full, do_push, do_pop;

   always_comb begin
      full    = (cnt_q == CntW'(Depth));
      do_pop  = (cnt_q != '0) && rd_en_i;
      // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
      do_push = wr_en_i && (!full || do_pop);
      wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d  = do_pop  ? rptr_q + PtrW'(1) : rptr_q;
      cnt_d   = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
      ovf_d   = ovf_q | (wr_en_i && full && !do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wr_data_i;
      end
   end

   assign valid_o    = (cnt_q != '0);
   assign rd_data_o  = valid_o ? mem_q[rptr_q] : '0;
   assign count_o    = cnt_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/banda_output_collector.sv
// banda_output_collector: delays the assembly-line load strobe by LATENCY cycles, samples
// the result bit f when the delayed strobe fires, packs samples LSB-first into 8-bit words
// and queues the words in an output FIFO.
//   clk, clear_n           - clock, asynchronous active-low reset
//   load, f, flush         - input strobe, result bit, partial-word flush request
//   out_data, out_valid    - oldest queued word and non-empty flag
//   out_ready              - consumer accept
//   overflow, word_cnt     - sticky drop flag, words held
// Optional feature: define BANDA_COLLECT_PARITY_EN to add out_parity, the even parity of
// out_data, stored alongside each word.
module banda_output_collector
   import banda_pkg::*;
#(
   parameter int unsigned LATENCY = LATENCY_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              load,
   input  logic              f,
   input  logic              flush,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic [4:0]        word_cnt
`ifdef BANDA_COLLECT_PARITY_EN
   ,
   output logic              out_parity
`endif
);

`ifdef BANDA_COLLECT_PARITY_EN
   localparam int unsigned FifoW = WORD_W + 1;
`else
   localparam int unsigned FifoW = WORD_W;
`endif

   // Load delay line; its last stage marks the cycle f is valid.
   logic [LATENCY-1:0] dly_q, dly_d;
   logic               f_vld;

   always_comb begin
      dly_d    = dly_q << 1;
      dly_d[0] = load;
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) dly_q <= '0;
      else          dly_q <= dly_d;
   end

   assign f_vld = dly_q[LATENCY-1];

   // Packer FSM.
   pack_state_e       state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] sr_q, sr_d;
   logic [WORD_W-1:0] sample_word;
   logic              push;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= EMPTY;
         bit_cnt_q <= '0;
         sr_q      <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      if (push) begin
         state_d   = EMPTY;
         bit_cnt_d = '0;
         sr_d      = '0;
      end else if (f_vld) begin
         state_d   = FILLING;
         bit_cnt_d = bit_cnt_q + 3'd1;
         sr_d      = sample_word;
      end
   end

   // The word being pushed already includes a same-cycle sample; unfilled bits stay 0
   // because the shift register is cleared on every push.
   always_comb begin
      sample_word = sr_q;
      if (f_vld) sample_word[bit_cnt_q] = f;
      push = 1'b0;
      unique case (state_q)
         EMPTY:   push = f_vld && flush;
         FILLING: push = (f_vld && (bit_cnt_q == 3'd7)) || flush;
      endcase
   end

   logic [FifoW-1:0]         wr_word, rd_word;
   logic [$clog2(DEPTH):0]   fifo_cnt;

`ifdef BANDA_COLLECT_PARITY_EN
   assign wr_word                = {^sample_word, sample_word};
   assign {out_parity, out_data} = rd_word;
`else
   assign wr_word  = sample_word;
   assign out_data = rd_word;
`endif

   banda_sync_fifo #(
      .Width (FifoW),
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i      (clk),
      .rst_ni     (clear_n),
      .wr_en_i    (push),
      .wr_data_i  (wr_word),
      .rd_en_i    (out_ready),
      .rd_data_o  (rd_word),
      .valid_o    (out_valid),
      .count_o    (fifo_cnt),
      .overflow_o (overflow)
   );

   assign word_cnt = 5'(fifo_cnt);

endmodule
